retire_commit_ctrl: RTL and testbench
=====================================

Name: retire_commit_ctrl

Overview:
Parametrised in-order retirement controller for the R10K-style core. It sits between the ROB head window and the arch map table, freelist, store queue and fetch. It commits up to RETIRE_W complete ROB head entries per cycle. Beyond plain retirement it adds a store-commit valid/ready handshake, a multi-cycle mispredict recovery FSM, a sticky halt state and a free-running retired-instruction counter.

Parameters:
RETIRE_W, 3, head-window lanes inspected and committable per cycle (1..8)
ROB_IDX_W, 5, ROB index width
PHYS_W, 6, physical tag width; PRF size = 2**PHYS_W
ARCH_W, 5, architectural register index width; register 0 is the zero register
RECOVER_CYCLES, 2, cycles retirement is blocked after a mispredict commit (>=1)
CNT_W, 32, retired-instruction counter width

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
head_valid  in  RETIRE_W  lane holds a ROB entry; lane 0 is oldest
head_complete  in  RETIRE_W  entry finished execution
head_is_branch  in  RETIRE_W  entry is a control-flow instruction
head_is_store  in  RETIRE_W  entry is a store
head_halt  in  RETIRE_W  entry is a halt instruction
head_pred_taken / head_act_taken  in  RETIRE_W each  predicted / actual direction
head_pred_target / head_act_target  in  RETIRE_W*32 each  predicted / actual target
head_arch_rd  in  RETIRE_W*ARCH_W  destination arch register
head_phys_rd / head_prev_phys_rd  in  RETIRE_W*PHYS_W each  new tag / tag being overwritten
head_rob_idx  in  RETIRE_W*ROB_IDX_W  ROB index per lane
store_commit_ready  in  1  store queue accepts a store commit this cycle
retire_count  out  $clog2(RETIRE_W+1)  entries popped from the ROB this cycle
arch_we  out  RETIRE_W  arch map table write enable
arch_addr  out  RETIRE_W*ARCH_W  arch map table write address
arch_phys  out  RETIRE_W*PHYS_W  arch map table write data
free_mask  out  2**PHYS_W  one-hot bitmap of tags returned to the freelist
store_commit_valid  out  1  a store at the commit boundary is requesting commit
store_commit_idx  out  ROB_IDX_W  ROB index of that store
mispredict  out  1  one-cycle flush pulse
flush_rob_idx  out  ROB_IDX_W  ROB index of the mispredicted branch
redirect_pc  out  32  correct fetch target after the mispredict
recovering  out  1  FSM is in RECOVER
halted  out  1  sticky halt retired
retired_total  out  CNT_W  wrapping count of committed entries

Behaviour:
- States: RUN, RECOVER, HALTED. State and the counters are registered. All commit outputs are combinational from the current state and the head inputs, so commit happens in the same cycle.
- Reset: state=RUN, recovery counter=0, retired_total=0. All outputs are 0 during reset. Reset asserted mid-RECOVER or in HALTED returns the block to RUN on the next edge.
- RUN lane scan, oldest to youngest, stops at the first lane that meets any of these:
  - the lane is not valid;
  - the lane is not complete;
  - the lane is the second store in the window;
  - the lane is a store and store_commit_ready=0.
- An invalid lane terminates the scan; younger lanes are never committed across a gap.
- Committed lane, not a branch and arch_rd!=0:
  - arch_we=1, arch_addr=arch_rd, arch_phys=phys_rd;
  - if prev_phys_rd!=0, free_mask[prev_phys_rd]=1.
- Branches never write arch state.
- Store handshake:
  - store_commit_valid=1 and store_commit_idx=rob_idx when the scan reaches a complete store lane, regardless of ready.
  - The store commits only in a cycle where valid and ready are both 1.
  - store_commit_valid must not depend combinationally on store_commit_ready.
- Branch misprediction: (pred_taken!=act_taken) OR (act_taken AND pred_target!=act_target).
  - On a mispredicted committed branch: the branch commits and younger lanes are blocked.
  - mispredict=1, flush_rob_idx=rob_idx, redirect_pc = act_target if taken, else 0. Fetch computes PC+4 itself for the not-taken case.
  - Next state is RECOVER with counter=RECOVER_CYCLES.
- Halt: a committed halt lane commits itself and blocks younger lanes; next state is HALTED.
  - If the halt and a mispredict fall in the same window, the oldest one wins.
- RECOVER: retire_count=0 and all commit outputs are 0; recovering=1.
  - The counter decrements each cycle; at 1 the state returns to RUN.
  - Head inputs are ignored, because the ROB is flushing.
- HALTED: no commits; halted=1 until reset.
- retire_count = number of lanes committed. retired_total += retire_count each cycle and wraps modulo 2**CNT_W.
- free_mask may contain up to RETIRE_W bits. Duplicate prev tags are ORed.

Test Plan:
- Three valid, complete ALU lanes writing r1/r2/r3 with prev tags 33/34/35 -> retire_count=3, arch_we=3'b111, free_mask bits 33,34,35 set, retired_total=3.
- Lane0 complete, lane1 incomplete, lane2 complete -> retire_count=1; lane2 is not committed.
- Lane0 is a store with ready=0 for 2 cycles, then ready=1 -> store_commit_valid=1 for all 3 cycles, retire_count=0,0,1. A window with two stores commits only the first.
- Lane1 is a branch with pred_taken=0, act_taken=1, target 0x100 -> mispredict pulse, redirect_pc=0x100, retire_count=2, recovering=1 for exactly 2 cycles with zero commits, then RUN.
- Lane0 is a halt, lane1 is a valid ALU op -> retire_count=1, halted=1 sticky. Asserting reset clears halted and retired_total.
- retired_total preset near wrap (CNT_W=4, 15 retired, then 2 more) -> value wraps to 1.

Source files
------------

// File: rtl/retire_commit_ctrl.sv
// -----------------------------------------------------------------------------
// retire_commit_ctrl
//
// In-order retirement controller for the R10K-style core. Each cycle it scans
// the ROB head window from the oldest lane (lane 0) toward the youngest. It
// commits every complete entry up to the first one that cannot retire yet.
// Commit outputs are combinational from the current state and the head inputs,
// so an entry retires in the same cycle it is presented.
//
// The scan stops at the first lane that is:
//   - invalid or incomplete,
//   - a second store in the window,
//   - a store that the store queue is not ready to accept.
// After a mispredicted branch or a halt instruction commits, no younger lane
// in the window commits.
//
// Ports:
//   clock, reset            clock; synchronous active-high reset
//   head_*                  per-lane ROB head window (lane 0 oldest), flat buses
//   store_commit_ready      store queue accepts a store commit this cycle
//   retire_count            number of entries popped from the ROB this cycle
//   arch_we/addr/phys       arch map table write port, one per lane
//   free_mask               one-hot bitmap of tags returned to the freelist
//   store_commit_valid/idx  store commit request (does not depend on ready)
//   mispredict              one-cycle flush pulse
//   flush_rob_idx           ROB index of the mispredicted branch
//   redirect_pc             correct fetch target (0 when not taken)
//   recovering, halted      FSM status
//   retired_total           wrapping count of committed entries
// -----------------------------------------------------------------------------
module retire_commit_ctrl #(
    parameter int RETIRE_W       = 3,
    parameter int ROB_IDX_W      = 5,
    parameter int PHYS_W         = 6,
    parameter int ARCH_W         = 5,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_W          = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [RETIRE_W-1:0]               head_valid,
    input  logic [RETIRE_W-1:0]               head_complete,
    input  logic [RETIRE_W-1:0]               head_is_branch,
    input  logic [RETIRE_W-1:0]               head_is_store,
    input  logic [RETIRE_W-1:0]               head_halt,
    input  logic [RETIRE_W-1:0]               head_pred_taken,
    input  logic [RETIRE_W-1:0]               head_act_taken,
    input  logic [RETIRE_W*32-1:0]            head_pred_target,
    input  logic [RETIRE_W*32-1:0]            head_act_target,
    input  logic [RETIRE_W*ARCH_W-1:0]        head_arch_rd,
    input  logic [RETIRE_W*PHYS_W-1:0]        head_phys_rd,
    input  logic [RETIRE_W*PHYS_W-1:0]        head_prev_phys_rd,
    input  logic [RETIRE_W*ROB_IDX_W-1:0]     head_rob_idx,
    input  logic                              store_commit_ready,
    output logic [$clog2(RETIRE_W+1)-1:0]     retire_count,
    output logic [RETIRE_W-1:0]               arch_we,
    output logic [RETIRE_W*ARCH_W-1:0]        arch_addr,
    output logic [RETIRE_W*PHYS_W-1:0]        arch_phys,
    output logic [(1<<PHYS_W)-1:0]            free_mask,
    output logic                              store_commit_valid,
    output logic [ROB_IDX_W-1:0]              store_commit_idx,
    output logic                              mispredict,
    output logic [ROB_IDX_W-1:0]              flush_rob_idx,
    output logic [31:0]                       redirect_pc,
    output logic                              recovering,
    output logic                              halted,
    output logic [CNT_W-1:0]                  retired_total
);

    localparam int CW   = $clog2(RETIRE_W + 1);
    localparam int RC_W = $clog2(RECOVER_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [RC_W-1:0]     rc_q, rc_d;
    logic [CNT_W-1:0]    total_q;
    logic [RETIRE_W-1:0] lane_misp;
    logic                scan_stop;
    logic                store_seen;

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values,
        // independent of statement order.
        if (reset) begin
            state_q <= RUN;
            rc_q    <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            total_q <= total_q + CNT_W'(retire_count);
        end
    end

    // Wrong direction, or right (taken) direction but wrong target.
    always_comb begin
        for (int i = 0; i < RETIRE_W; i++) begin
            lane_misp[i] = (head_pred_taken[i] != head_act_taken[i]) ||
                           (head_act_taken[i] &&
                            (head_pred_target[i*32 +: 32] != head_act_target[i*32 +: 32]));
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through
        // the case/loop can infer a latch.
        retire_count       = '0;
        arch_we            = '0;
        arch_addr          = '0;
        arch_phys          = '0;
        free_mask          = '0;
        store_commit_valid = 1'b0;
        store_commit_idx   = '0;
        mispredict         = 1'b0;
        flush_rob_idx      = '0;
        redirect_pc        = '0;
        state_d            = state_q;
        rc_d               = rc_q;
        scan_stop          = 1'b0;
        store_seen         = 1'b0;

        if (!reset) begin
            case (state_q)
                RUN: begin
                    for (int i = 0; i < RETIRE_W; i++) begin
                        if (!scan_stop) begin
                            if (!head_valid[i] || !head_complete[i]) begin
                                scan_stop = 1'b1;
                            end else if (head_is_store[i] && store_seen) begin
                                // Only one store may commit per cycle.
                                scan_stop = 1'b1;
                            end else begin
                                // The request is raised before looking at ready.
                                // Only an older store could stop the scan here,
                                // and that case is caught by store_seen.
                                // So valid never depends on ready.
                                if (head_is_store[i]) begin
                                    store_seen         = 1'b1;
                                    store_commit_valid = 1'b1;
                                    store_commit_idx   = head_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                                end
                                if (head_is_store[i] && !store_commit_ready) begin
                                    scan_stop = 1'b1;
                                end else begin
                                    retire_count = retire_count + CW'(1);
                                    if (!head_is_branch[i] &&
                                        (head_arch_rd[i*ARCH_W +: ARCH_W] != '0)) begin
                                        arch_we[i]                      = 1'b1;
                                        arch_addr[i*ARCH_W +: ARCH_W]   = head_arch_rd[i*ARCH_W +: ARCH_W];
                                        arch_phys[i*PHYS_W +: PHYS_W]   = head_phys_rd[i*PHYS_W +: PHYS_W];
                                        if (head_prev_phys_rd[i*PHYS_W +: PHYS_W] != '0) begin
                                            free_mask[head_prev_phys_rd[i*PHYS_W +: PHYS_W]] = 1'b1;
                                        end
                                    end
                                    // The scan stops here, so the oldest of a
                                    // mispredict or a halt always wins.
                                    if (head_is_branch[i] && lane_misp[i]) begin
                                        mispredict    = 1'b1;
                                        flush_rob_idx = head_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                                        redirect_pc   = head_act_taken[i] ?
                                                        head_act_target[i*32 +: 32] : 32'd0;
                                        state_d       = RECOVER;
                                        rc_d          = RC_W'(RECOVER_CYCLES);
                                        scan_stop     = 1'b1;
                                    end else if (head_halt[i]) begin
                                        state_d   = HALTED;
                                        scan_stop = 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                RECOVER: begin
                    // The ROB is flushing, so the head window is ignored.
                    if (rc_q <= RC_W'(1)) begin
                        state_d = RUN;
                        rc_d    = '0;
                    end else begin
                        rc_d = rc_q - RC_W'(1);
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = RUN;
                    rc_d    = '0;
                end
            endcase
        end
    end

    assign recovering    = !reset && (state_q == RECOVER);
    assign halted        = !reset && (state_q == HALTED);
    assign retired_total = reset ? '0 : total_q;

endmodule

// File: tb/tb_retire_commit_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for retire_commit_ctrl (RETIRE_W=3).
//
// Each vector holds a head window and its expected outputs. Lane l always uses
// these fields:
//   arch_rd = l+1 (0 if rd0[l]), phys_rd = 10+l,
//   prev_phys_rd = 33+l (0 if prev0[l]), rob_idx = 4+l.
// Expected outputs go onto a scoreboard queue when a vector is driven. They are
// popped and compared on the falling edge. retired_total is checked after the
// following rising edge.
//
// A second instance with CNT_W=4 sees the same stimulus and checks counter wrap.
// -----------------------------------------------------------------------------
module tb_retire_commit_ctrl;

    localparam int RW  = 3;
    localparam int RIW = 5;
    localparam int PW  = 6;
    localparam int AW  = 5;

    localparam logic [63:0] F33 = 64'd1 << 33;
    localparam logic [63:0] F34 = 64'd1 << 34;
    localparam logic [63:0] F35 = 64'd1 << 35;

    typedef struct packed {
        logic [1:0]  count;
        logic [2:0]  we;
        logic [63:0] free;
        logic        sv;
        logic [4:0]  sidx;
        logic        misp;
        logic [4:0]  flush;
        logic [31:0] redir;
        logic        rec;
        logic        halt;
    } exp_t;

    typedef struct packed {
        logic [2:0]  valid;
        logic [2:0]  complete;
        logic [2:0]  br;
        logic [2:0]  st;
        logic [2:0]  ht;
        logic [2:0]  pt;
        logic [2:0]  at;
        logic [2:0]  rd0;
        logic [2:0]  prev0;
        logic        ready;
        logic [31:0] ptgt;
        logic [31:0] atgt;
        exp_t        e;
    } vec_t;

    logic               clock;
    logic               reset;
    logic [RW-1:0]      head_valid, head_complete, head_is_branch, head_is_store, head_halt;
    logic [RW-1:0]      head_pred_taken, head_act_taken;
    logic [RW*32-1:0]   head_pred_target, head_act_target;
    logic [RW*AW-1:0]   head_arch_rd;
    logic [RW*PW-1:0]   head_phys_rd, head_prev_phys_rd;
    logic [RW*RIW-1:0]  head_rob_idx;
    logic               store_commit_ready;

    logic [1:0]         retire_count;
    logic [RW-1:0]      arch_we;
    logic [RW*AW-1:0]   arch_addr;
    logic [RW*PW-1:0]   arch_phys;
    logic [63:0]        free_mask;
    logic               store_commit_valid;
    logic [RIW-1:0]     store_commit_idx;
    logic               mispredict;
    logic [RIW-1:0]     flush_rob_idx;
    logic [31:0]        redirect_pc;
    logic               recovering;
    logic               halted;
    logic [31:0]        retired_total;

    logic [1:0]         w4_retire_count;
    logic [RW-1:0]      w4_arch_we;
    logic [RW*AW-1:0]   w4_arch_addr;
    logic [RW*PW-1:0]   w4_arch_phys;
    logic [63:0]        w4_free_mask;
    logic               w4_store_commit_valid;
    logic [RIW-1:0]     w4_store_commit_idx;
    logic               w4_mispredict;
    logic [RIW-1:0]     w4_flush_rob_idx;
    logic [31:0]        w4_redirect_pc;
    logic               w4_recovering;
    logic               w4_halted;
    logic [3:0]         w4_retired_total;

    retire_commit_ctrl dut (
        .clock(clock), .reset(reset),
        .head_valid(head_valid), .head_complete(head_complete),
        .head_is_branch(head_is_branch), .head_is_store(head_is_store), .head_halt(head_halt),
        .head_pred_taken(head_pred_taken), .head_act_taken(head_act_taken),
        .head_pred_target(head_pred_target), .head_act_target(head_act_target),
        .head_arch_rd(head_arch_rd), .head_phys_rd(head_phys_rd),
        .head_prev_phys_rd(head_prev_phys_rd), .head_rob_idx(head_rob_idx),
        .store_commit_ready(store_commit_ready),
        .retire_count(retire_count), .arch_we(arch_we), .arch_addr(arch_addr),
        .arch_phys(arch_phys), .free_mask(free_mask),
        .store_commit_valid(store_commit_valid), .store_commit_idx(store_commit_idx),
        .mispredict(mispredict), .flush_rob_idx(flush_rob_idx), .redirect_pc(redirect_pc),
        .recovering(recovering), .halted(halted), .retired_total(retired_total)
    );

    retire_commit_ctrl #(.CNT_W(4)) dut_w4 (
        .clock(clock), .reset(reset),
        .head_valid(head_valid), .head_complete(head_complete),
        .head_is_branch(head_is_branch), .head_is_store(head_is_store), .head_halt(head_halt),
        .head_pred_taken(head_pred_taken), .head_act_taken(head_act_taken),
        .head_pred_target(head_pred_target), .head_act_target(head_act_target),
        .head_arch_rd(head_arch_rd), .head_phys_rd(head_phys_rd),
        .head_prev_phys_rd(head_prev_phys_rd), .head_rob_idx(head_rob_idx),
        .store_commit_ready(store_commit_ready),
        .retire_count(w4_retire_count), .arch_we(w4_arch_we), .arch_addr(w4_arch_addr),
        .arch_phys(w4_arch_phys), .free_mask(w4_free_mask),
        .store_commit_valid(w4_store_commit_valid), .store_commit_idx(w4_store_commit_idx),
        .mispredict(w4_mispredict), .flush_rob_idx(w4_flush_rob_idx),
        .redirect_pc(w4_redirect_pc), .recovering(w4_recovering), .halted(w4_halted),
        .retired_total(w4_retired_total)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb[$];
    logic [31:0] exp_total;
    vec_t        tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vec_t mk(input logic [2:0] valid, complete, st, rd0, prev0,
                                input logic ready, input logic [1:0] cnt,
                                input logic [2:0] we, input logic [63:0] free,
                                input logic sv, input logic [4:0] sidx);
        vec_t v;
        v          = '0;
        v.valid    = valid;
        v.complete = complete;
        v.st       = st;
        v.rd0      = rd0;
        v.prev0    = prev0;
        v.ready    = ready;
        v.e.count  = cnt;
        v.e.we     = we;
        v.e.free   = free;
        v.e.sv     = sv;
        v.e.sidx   = sidx;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        head_valid         = v.valid;
        head_complete      = v.complete;
        head_is_branch     = v.br;
        head_is_store      = v.st;
        head_halt          = v.ht;
        head_pred_taken    = v.pt;
        head_act_taken     = v.at;
        store_commit_ready = v.ready;
        for (int l = 0; l < RW; l++) begin
            head_pred_target[l*32 +: 32]   = v.ptgt;
            head_act_target[l*32 +: 32]    = v.atgt;
            head_arch_rd[l*AW +: AW]       = v.rd0[l] ? 5'd0 : AW'(l + 1);
            head_phys_rd[l*PW +: PW]       = PW'(10 + l);
            head_prev_phys_rd[l*PW +: PW]  = v.prev0[l] ? 6'd0 : PW'(33 + l);
            head_rob_idx[l*RIW +: RIW]     = RIW'(4 + l);
        end
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        check({tag, " sb_has_entry"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " retire_count"}, 64'(retire_count), 64'(e.count));
            check({tag, " arch_we"}, 64'(arch_we), 64'(e.we));
            check({tag, " free_mask"}, free_mask, e.free);
            check({tag, " store_commit_valid"}, 64'(store_commit_valid), 64'(e.sv));
            if (e.sv) check({tag, " store_commit_idx"}, 64'(store_commit_idx), 64'(e.sidx));
            check({tag, " mispredict"}, 64'(mispredict), 64'(e.misp));
            if (e.misp) begin
                check({tag, " flush_rob_idx"}, 64'(flush_rob_idx), 64'(e.flush));
                check({tag, " redirect_pc"}, 64'(redirect_pc), 64'(e.redir));
            end
            check({tag, " recovering"}, 64'(recovering), 64'(e.rec));
            check({tag, " halted"}, 64'(halted), 64'(e.halt));
            for (int l = 0; l < RW; l++) begin
                if (e.we[l]) begin
                    check({tag, " arch_addr"}, 64'(arch_addr[l*AW +: AW]), 64'(l + 1));
                    check({tag, " arch_phys"}, 64'(arch_phys[l*PW +: PW]), 64'(10 + l));
                end
            end
        end
    endtask

    // Called just after a rising edge. Returns just after the next rising edge.
    task automatic run_vec(input string tag, input vec_t v);
        drive(v);
        sb.push_back(v.e);
        @(negedge clock);
        compare_outputs(tag);
        @(posedge clock);
        #1;
        exp_total = exp_total + 32'(v.e.count);
        check({tag, " retired_total"}, 64'(retired_total), 64'(exp_total));
    endtask

    // Drives a committable window during reset; every output must still read 0.
    task automatic do_reset(input string tag);
        exp_t z;
        z     = '0;
        reset = 1'b1;
        drive(tbl[0]);
        sb.push_back(z);
        @(negedge clock);
        compare_outputs({tag, " in_reset"});
        check({tag, " in_reset retired_total"}, 64'(retired_total), 64'd0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        exp_total = '0;
        check({tag, " post_reset retired_total"}, 64'(retired_total), 64'd0);
        check({tag, " post_reset w4_retired_total"}, 64'(w4_retired_total), 64'd0);
        check({tag, " post_reset halted"}, 64'(halted), 64'd0);
        check({tag, " post_reset recovering"}, 64'(recovering), 64'd0);
    endtask

    initial begin
        vec_t v;
        vec_t rec;
        vec_t hv;

        // valid, complete, store, rd0, prev0, ready | count, we, free, sv, sidx
        tbl[0]  = mk(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 2'd3, 3'b111, F33|F34|F35, 1'b0, 5'd0);
        tbl[1]  = mk(3'b111, 3'b101, 3'b000, 3'b000, 3'b000, 1'b1, 2'd1, 3'b001, F33,         1'b0, 5'd0);
        tbl[2]  = mk(3'b110, 3'b110, 3'b000, 3'b000, 3'b000, 1'b1, 2'd0, 3'b000, 64'd0,       1'b0, 5'd0);
        tbl[3]  = mk(3'b101, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 2'd1, 3'b001, F33,         1'b0, 5'd0);
        tbl[4]  = mk(3'b111, 3'b111, 3'b000, 3'b010, 3'b000, 1'b1, 2'd3, 3'b101, F33|F35,     1'b0, 5'd0);
        tbl[5]  = mk(3'b111, 3'b111, 3'b000, 3'b000, 3'b100, 1'b1, 2'd3, 3'b111, F33|F34,     1'b0, 5'd0);
        tbl[6]  = mk(3'b111, 3'b111, 3'b001, 3'b001, 3'b000, 1'b1, 2'd3, 3'b110, F34|F35,     1'b1, 5'd4);
        tbl[7]  = mk(3'b111, 3'b111, 3'b101, 3'b101, 3'b000, 1'b1, 2'd2, 3'b010, F34,         1'b1, 5'd4);
        tbl[8]  = mk(3'b111, 3'b111, 3'b010, 3'b010, 3'b000, 1'b0, 2'd1, 3'b001, F33,         1'b1, 5'd5);
        tbl[9]  = mk(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 2'd3, 3'b101, F33|F35,     1'b0, 5'd0);
        tbl[9].br = 3'b010;
        tbl[10] = tbl[9];
        tbl[10].pt   = 3'b010;
        tbl[10].at   = 3'b010;
        tbl[10].ptgt = 32'h40;
        tbl[10].atgt = 32'h40;
        tbl[11] = mk(3'b111, 3'b110, 3'b001, 3'b001, 3'b000, 1'b1, 2'd0, 3'b000, 64'd0,       1'b0, 5'd0);
        tbl[12] = mk(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 2'd3, 3'b111, F33|F34|F35, 1'b0, 5'd0);

        exp_total = '0;
        do_reset("init");

        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i]);
        end

        // The store stalls for two cycles. The request stays up while it waits.
        v = mk(3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 1'b0, 2'd0, 3'b000, 64'd0, 1'b1, 5'd4);
        run_vec("store_wait0", v);
        run_vec("store_wait1", v);
        v.ready   = 1'b1;
        v.e.count = 2'd1;
        run_vec("store_go", v);

        // Branch on lane 1: predicted not taken, actually taken to 0x100.
        v = mk(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 2'd2, 3'b001, F33, 1'b0, 5'd0);
        v.br = 3'b010;
        v.at = 3'b010;
        v.atgt = 32'h100;
        v.e.misp = 1'b1;
        v.e.flush = 5'd5;
        v.e.redir = 32'h100;
        run_vec("misp_dir", v);
        rec = v;
        rec.e = '0;
        rec.e.rec = 1'b1;
        run_vec("recover0", rec);
        run_vec("recover1", rec);
        run_vec("after_recover", tbl[0]);

        // Lane 2: taken as predicted, but the target differs.
        v = mk(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 2'd3, 3'b011, F33|F34, 1'b0, 5'd0);
        v.br = 3'b100;
        v.pt = 3'b100;
        v.at = 3'b100;
        v.ptgt = 32'h200;
        v.atgt = 32'h100;
        v.e.misp = 1'b1;
        v.e.flush = 5'd6;
        v.e.redir = 32'h100;
        run_vec("misp_tgt", v);
        run_vec("recover_t0", rec);
        run_vec("recover_t1", rec);

        // Lane 0: predicted taken, actually not taken, so redirect_pc is 0.
        // Then reset while in RECOVER.
        v = mk(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 2'd1, 3'b000, 64'd0, 1'b0, 5'd0);
        v.br = 3'b001;
        v.pt = 3'b001;
        v.ptgt = 32'h300;
        v.atgt = 32'h300;
        v.e.misp = 1'b1;
        v.e.flush = 5'd4;
        v.e.redir = 32'd0;
        run_vec("misp_nt", v);
        do_reset("mid_recover");
        run_vec("run_after_reset", tbl[0]);

        // Halt on lane 0. The younger ALU op and the mispredicted branch must not commit.
        v = mk(3'b111, 3'b111, 3'b000, 3'b001, 3'b000, 1'b1, 2'd1, 3'b000, 64'd0, 1'b0, 5'd0);
        v.ht = 3'b001;
        v.br = 3'b100;
        v.at = 3'b100;
        v.atgt = 32'h500;
        run_vec("halt", v);
        hv = tbl[0];
        hv.e = '0;
        hv.e.halt = 1'b1;
        run_vec("halted0", hv);
        run_vec("halted1", hv);
        do_reset("halt_clear");

        // The 4-bit counter reaches 15, then wraps to 1 after two more entries.
        for (int i = 0; i < 5; i++) begin
            run_vec($sformatf("fill%0d", i), tbl[0]);
        end
        check("w4_total_15", 64'(w4_retired_total), 64'd15);
        run_vec("wrap", tbl[7]);
        check("w4_total_wrap", 64'(w4_retired_total), 64'd1);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
